reg_writeback_ctrl: RTL

//  Writer side of the register-file write port (WriteEn/Waddr/DataIn). Collects results from
//  two producers (ALU, data-memory load), buffers them in a small in-order FIFO and retires
//  at most one register write per cycle. Exports a per-register pending bitmap so decode can

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_fifo.sv | 72 +++++++
 rtl/reg_writeback_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the register writeback path: the buffered
// {addr,data} entry and the default datapath geometry.
package cpu_pkg;

  localparam int CPU_W     = 8;
  localparam int CPU_A     = 2;
  localparam int CPU_DEPTH = 4;

  typedef struct packed {
    logic [CPU_A-1:0] addr;
    logic [CPU_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Two-write / one-read circular buffer of writeback entries. Write port 0 lands
// at wr_ptr and port 1 right behind it; the head is read combinationally.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = CPU_DEPTH
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       i_wr0_en,
  input  wb_entry_t                  i_wr0_entry,
  input  logic                       i_wr1_en,
  input  wb_entry_t                  i_wr1_entry,
  input  logic                       i_pop,
  output wb_entry_t                  o_head,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [DEPTH-1:0]           o_valid,
  output wb_entry_t                  o_entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_mem [DEPTH];

  logic [PW-1:0]    w_slot0;
  logic [PW-1:0]    w_slot1;
  logic [PW-1:0]    w_head_slot;
  logic [DEPTH-1:0] w_valid_next;

  assign w_slot0     = r_wr_ptr[PW-1:0];
  assign w_slot1     = r_wr_ptr[PW-1:0] + PW'(i_wr0_en);
  assign w_head_slot = r_rd_ptr[PW-1:0];

  // Clear before set: when full, the slot popped this cycle may be refilled.
  always_comb begin
    w_valid_next = r_valid;
    if (i_pop)    w_valid_next[w_head_slot] = 1'b0;
    if (i_wr0_en) w_valid_next[w_slot0]     = 1'b1;
    if (i_wr1_en) w_valid_next[w_slot1]     = 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + (PW+1)'(i_wr0_en) + (PW+1)'(i_wr1_en);
      r_rd_ptr <= r_rd_ptr + (PW+1)'(i_pop);
      r_count  <= r_count + (PW+1)'(i_wr0_en) + (PW+1)'(i_wr1_en) - (PW+1)'(i_pop);
      r_valid  <= w_valid_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (i_wr0_en) r_mem[w_slot0] <= i_wr0_entry;
    if (i_wr1_en) r_mem[w_slot1] <= i_wr1_entry;
  end

  assign o_head    = r_mem[w_head_slot];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_count   = r_count;
  assign o_valid   = r_valid;
  assign o_entries = r_mem;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writer: arbitrates ALU/load results into an in-order FIFO,
// retires one write per cycle and publishes a per-register pending bitmap.
module reg_writeback_ctrl
  import cpu_pkg::*;
#(
  parameter int W     = CPU_W,
  parameter int A     = CPU_A,
  parameter int DEPTH = CPU_DEPTH
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    AluValid,
  input  logic [A-1:0]            AluAddr,
  input  logic [W-1:0]            AluData,
  output logic                    AluReady,
  input  logic                    MemValid,
  input  logic [A-1:0]            MemAddr,
  input  logic [W-1:0]            MemData,
  output logic                    MemReady,
  output logic                    WriteEn,
  output logic [A-1:0]            Waddr,
  output logic [W-1:0]            DataIn,
  output logic [2**A-1:0]         Pending,
  output logic [$clog2(DEPTH):0]  Count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int NR = 2**A;

  wb_entry_t        w_head;
  wb_entry_t        w_entries [DEPTH];
  wb_entry_t        w_mem_entry;
  wb_entry_t        w_alu_entry;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [DEPTH-1:0] w_valid;
  logic             w_pop;
  logic [CW:0]      w_free;
  logic             w_mem_acc;
  logic             w_alu_acc;

  assign w_pop  = !Reset && !w_empty;
  // A slot vacated by this cycle's retire can be refilled in the same cycle.
  assign w_free = (CW+1)'(DEPTH) - {1'b0, w_count} + (CW+1)'(w_pop);

  assign MemReady  = !Reset && (w_free >= (CW+1)'(1));
  assign AluReady  = !Reset && (MemValid ? (w_free >= (CW+1)'(2)) : (w_free >= (CW+1)'(1)));
  assign w_mem_acc = MemValid && MemReady;
  assign w_alu_acc = AluValid && AluReady;

  assign w_mem_entry = '{addr: MemAddr, data: MemData};
  assign w_alu_entry = '{addr: AluAddr, data: AluData};

  // The load is older in program order, so it takes the first slot.
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .i_wr0_en    (w_mem_acc),
    .i_wr0_entry (w_mem_entry),
    .i_wr1_en    (w_alu_acc),
    .i_wr1_entry (w_alu_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_valid     (w_valid),
    .o_entries   (w_entries)
  );

  assign WriteEn = w_pop;
  assign Waddr   = w_pop ? w_head.addr : '0;
  assign DataIn  = w_pop ? w_head.data : '0;
  assign Count   = w_count;

  genvar gi;
  generate
    for (gi = 0; gi < NR; gi++) begin : g_pending
      logic [DEPTH-1:0] w_hit;
      always_comb begin
        w_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
          w_hit[e] = w_valid[e] && (w_entries[e].addr == A'(gi));
        end
      end
      assign Pending[gi] = |w_hit;
    end
  endgenerate

endmodule
